// File: rtl/ttt_game_controller.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, moves the cursor, alternates X/O
// and reports wins/draws to the grid renderer. Every output is a register.
module ttt_game_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        left,
  input  logic        right,
  input  logic        enter,
  output logic [8:0]  cursor,
  output logic [17:0] board,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_line,
  output logic [3:0]  move_count
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

  // Rows, columns and diagonals as cell masks (bit k = cell k).
  localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                       9'h092, 9'h124, 9'h111, 9'h054};

  state_t     state;
  logic       start_q, left_q, right_q, enter_q;
  logic       start_p, left_p, right_p, enter_p;
  logic [1:0] mark;
  logic [8:0] occupied;
  logic       cell_busy;
  logic [8:0] win_mask;

  function automatic logic [8:0] line_hits(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] match;
    logic [8:0] hits;
    for (int k = 0; k < 9; k++) match[k] = (b[2*k +: 2] == m);
    hits = '0;
    for (int l = 0; l < 8; l++)
      if ((match & LINES[l]) == LINES[l]) hits = hits | LINES[l];
    return hits;
  endfunction

  assign start_p = start & ~start_q;
  assign left_p  = left  & ~left_q;
  assign right_p = right & ~right_q;
  assign enter_p = enter & ~enter_q;
  assign mark    = turn ? 2'b10 : 2'b01;

  always_comb begin
    occupied = '0;
    for (int k = 0; k < 9; k++) occupied[k] = |board[2*k +: 2];
  end

  assign cell_busy = |(occupied & cursor);
  assign win_mask  = line_hits(board, mark);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      // Previous samples start high so a button held through reset is not a press.
      start_q    <= 1'b1;
      left_q     <= 1'b1;
      right_q    <= 1'b1;
      enter_q    <= 1'b1;
      cursor     <= 9'b000000001;
      board      <= '0;
      turn       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      win_line   <= '0;
      move_count <= '0;
    end else begin
      start_q <= start;
      left_q  <= left;
      right_q <= right;
      enter_q <= enter;
      // CHECK swallows every press, start included.
      if (start_p && state != CHECK) begin
        state      <= PLAY;
        cursor     <= 9'b000000001;
        board      <= '0;
        turn       <= 1'b0;
        game_over  <= 1'b0;
        winner     <= 2'b00;
        win_line   <= '0;
        move_count <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (enter_p && !cell_busy) begin
              for (int k = 0; k < 9; k++)
                if (cursor[k]) board[2*k +: 2] <= mark;
              move_count <= move_count + 4'd1;
              state      <= CHECK;
            end else if (left_p ^ right_p) begin
              cursor <= right_p ? {cursor[7:0], cursor[8]} : {cursor[0], cursor[8:1]};
            end
          end
          CHECK: begin
            if (win_mask != '0) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= mark;
              win_line  <= win_mask;
            end else if (move_count == 4'd9) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 2'b11;
            end else begin
              turn  <= ~turn;
              state <= PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_controller.sv
// Directed bench for ttt_game_controller: cursor wrap, placement, win, draw,
// edge-detect corner cases, restart and asynchronous reset mid-game.
module tb_ttt_game_controller;

  logic        clk = 1'b0;
  logic        reset, start, left, right, enter;
  logic [8:0]  cursor;
  logic [17:0] board;
  logic        turn, game_over;
  logic [1:0]  winner;
  logic [8:0]  win_line;
  logic [3:0]  move_count;

  int errors = 0;
  int checks = 0;

  ttt_game_controller dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .enter(enter), .cursor(cursor), .board(board), .turn(turn),
    .game_over(game_over), .winner(winner), .win_line(win_line),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic press_right();
    right = 1'b1; tick(); right = 1'b0; tick();
  endtask

  task automatic press_left();
    left = 1'b1; tick(); left = 1'b0; tick();
  endtask

  // Enter pulse: first edge places the mark, second edge registers the check.
  task automatic press_enter();
    enter = 1'b1; tick(); enter = 1'b0; tick();
  endtask

  task automatic goto_cell(input int k);
    logic [8:0] tgt;
    tgt = '0;
    tgt[k] = 1'b1;
    for (int i = 0; i < 9 && cursor !== tgt; i++) press_right();
    chk("goto_cell", 32'(cursor), 32'(tgt));
  endtask

  task automatic place(input int k);
    goto_cell(k);
    press_enter();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cursor"}, 32'(cursor), 32'h1);
    chk({tag, "_board"}, 32'(board), 32'h0);
    chk({tag, "_turn"}, 32'(turn), 32'h0);
    chk({tag, "_over"}, 32'(game_over), 32'h0);
    chk({tag, "_winner"}, 32'(winner), 32'h0);
    chk({tag, "_winline"}, 32'(win_line), 32'h0);
    chk({tag, "_count"}, 32'(move_count), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0; enter = 1'b1;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Enter held across reset release and through start: never a press.
    press_start();
    tick();
    chk("held_enter_board", 32'(board), 32'h0);
    chk("held_enter_count", 32'(move_count), 32'h0);
    enter = 1'b0;
    tick();

    // Cursor wrap.
    press_right();
    chk("right1", 32'(cursor), 32'h002);
    for (int i = 0; i < 8; i++) press_right();
    chk("right9_wrap", 32'(cursor), 32'h001);
    press_left();
    chk("left_wrap", 32'(cursor), 32'h100);
    chk("wrap_board", 32'(board), 32'h0);
    press_right();

    // Placement latency and occupied-cell rejection.
    enter = 1'b1; tick();
    chk("place_board", 32'(board), 32'h1);
    chk("place_count", 32'(move_count), 32'h1);
    chk("place_turn_n", 32'(turn), 32'h0);
    enter = 1'b0; tick();
    chk("place_turn_n1", 32'(turn), 32'h1);
    press_enter();
    chk("occ_board", 32'(board), 32'h1);
    chk("occ_count", 32'(move_count), 32'h1);
    chk("occ_turn", 32'(turn), 32'h1);

    // X wins on the top row.
    press_start();
    chk("restart_board", 32'(board), 32'h0);
    chk("restart_turn", 32'(turn), 32'h0);
    place(0); place(3); place(1); place(4);
    goto_cell(2);
    enter = 1'b1; tick();
    chk("win_pre_count", 32'(move_count), 32'h5);
    chk("win_pre_over", 32'(game_over), 32'h0);
    enter = 1'b0; tick();
    chk("win_over", 32'(game_over), 32'h1);
    chk("win_winner", 32'(winner), 32'h1);
    chk("win_line", 32'(win_line), 32'h007);
    chk("win_board", 32'(board), 32'h295);
    chk("win_turn", 32'(turn), 32'h0);
    press_right();
    press_enter();
    chk("over_cursor", 32'(cursor), 32'h004);
    chk("over_board", 32'(board), 32'h295);
    chk("over_count", 32'(move_count), 32'h5);

    // Draw.
    press_start();
    place(0); place(1); place(2); place(4); place(3);
    place(5); place(7); place(6);
    chk("draw_pre_over", 32'(game_over), 32'h0);
    place(8);
    chk("draw_winner", 32'(winner), 32'h3);
    chk("draw_winline", 32'(win_line), 32'h0);
    chk("draw_count", 32'(move_count), 32'h9);
    chk("draw_over", 32'(game_over), 32'h1);
    chk("draw_board", 32'(board), 32'h16A59);

    // Simultaneous presses, then restart mid-game.
    press_start();
    place(0); place(1); place(2); place(4);
    enter = 1'b1; right = 1'b1; tick();
    chk("enter_occ_right_cursor", 32'(cursor), 32'h020);
    chk("enter_occ_right_count", 32'(move_count), 32'h4);
    enter = 1'b0; right = 1'b0; tick();
    enter = 1'b1; left = 1'b1; tick();
    chk("enter_left_cursor", 32'(cursor), 32'h020);
    chk("enter_left_board", 32'(board[11:10]), 32'h1);
    enter = 1'b0; left = 1'b0; tick();
    chk("enter_left_turn", 32'(turn), 32'h1);
    left = 1'b1; right = 1'b1; tick();
    chk("lr_same_edge", 32'(cursor), 32'h020);
    left = 1'b0; right = 1'b0; tick();
    press_start();
    chk("mid_restart_board", 32'(board), 32'h0);
    chk("mid_restart_turn", 32'(turn), 32'h0);
    chk("mid_restart_cursor", 32'(cursor), 32'h001);
    chk("mid_restart_count", 32'(move_count), 32'h0);

    // Asynchronous reset while in CHECK.
    goto_cell(1);
    enter = 1'b1; tick();
    enter = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    tick();
    reset = 1'b0;
    tick();
    press_enter();
    chk("idle_enter_board", 32'(board), 32'h0);
    chk("idle_enter_count", 32'(move_count), 32'h0);
    press_start();
    press_enter();
    chk("after_reset_board", 32'(board), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttt_game_controller.md
# ttt_game_controller

Turn sequencer and board-state owner for the 3x3 tic-tac-toe grid. Turns button presses into cursor moves, alternates X and O placements and detects wins and draws. Exposes the one-hot cursor, the per-cell marks and the result to the VGA grid renderer, which only draws what this block reports. One instance sits between the button synchronisers and the display.

## Interface
Parameters:
- none (grid fixed at 3x3; cell k = column k%3, row k/3; k=0 is G00, k=1 G10, k=2 G20, k=3 G01 … k=8 G22)

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  level, already synchronised; rising edge starts or restarts a game
- left  in  1  level; rising edge moves the cursor back one cell
- right  in  1  level; rising edge moves the cursor forward one cell
- enter  in  1  level; rising edge places the current player's mark at the cursor
- cursor  out  9  one-hot cursor position, bit k = cell k
- board  out  18  two bits per cell at [2k+1:2k]: 00 empty, 01 X, 10 O
- turn  out  1  0 = X to move, 1 = O to move
- game_over  out  1  high in OVER state
- winner  out  2  00 none, 01 X, 10 O, 11 draw
- win_line  out  9  mask of cells on completed line(s); zero unless a player won
- move_count  out  4  marks placed, 0..9

## Operation
- Edge detection: per input, a registered copy of the previous sample; press = input high now AND previous sample low. Previous-sample registers reset to 1, so a button held through reset release is not a press.
- States:
  - IDLE: reached after reset. Only start is honoured.
  - PLAY: moves and placements.
  - CHECK: one-cycle evaluation. Presses occurring here are discarded, not queued.
  - OVER: result held. Only start is honoured.
- IDLE --start--> PLAY. Board is cleared, cursor=bit0, turn=0, move_count=0, winner=00, win_line=0.
- PLAY, start press: restart with the same clearing as IDLE->PLAY. Start has priority over every other input.
- PLAY, cursor movement:
  - right: cursor rotates toward the MSB; bit8 wraps to bit0.
  - left: cursor rotates toward the LSB; bit0 wraps to bit8.
  - left and right pressed on the same edge: both are ignored.
- PLAY, enter on an empty cell: write 01 (turn=0) or 10 (turn=1) at the cursor, increment move_count, go to CHECK. The cursor does not move even if left or right is pressed on the same edge.
- PLAY, enter on an occupied cell: ignored. The state is unchanged and any simultaneous left or right is applied normally.
- CHECK: test the 8 lines (3 rows, 3 columns, 2 diagonals) for three cells equal to the mark just placed.
  - Any line complete: go to OVER, winner=mark, win_line=OR of all complete lines.
  - Otherwise, move_count=9: go to OVER, winner=11.
  - Otherwise: turn toggles and the state returns to PLAY.
- OVER --start--> PLAY with clearing. left, right and enter are ignored.
- Reset mid-game: every output immediately takes its reset value. No partial state survives.

## Timing
- Reset values: cursor=9'b000000001, board=0, turn=0, game_over=0, winner=00, win_line=0, move_count=0. State is IDLE.
- Cursor move: cursor changes on the same clk edge that samples the press (press-to-output latency is 1 edge).
- Placement, with the enter press sampled at edge N:
  - At edge N: board and move_count update.
  - At edge N+1: the CHECK result is registered. winner, win_line and game_over change, or turn toggles.
- Minimum spacing between accepted placements is 2 cycles. Inputs are not buffered.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, start, then right pressed 9 times -> cursor wraps back to bit0. Then left once -> cursor=bit8; board=0 throughout.
- Start; enter at cell 0 -> board[1:0]=01, move_count=1, and one cycle later turn=1. Enter again at cell 0 -> no change, turn stays 1.
- X plays cells 0,1,2 and O plays cells 3,4 -> after X places cell 2, the next cycle gives game_over=1, winner=01, win_line=9'b000000111. Further enter or right presses -> no change.
- Draw sequence X:0,2,3,7,8 / O:1,4,5,6 -> after the ninth mark, winner=11, win_line=0, move_count=9.
- Enter held across reset release, then kept high -> no placement. left and right pressed on the same edge -> cursor unchanged. Start during PLAY with 4 marks placed -> board=0, turn=0, cursor=bit0.
- Reset asserted the cycle after an enter (during CHECK) -> all outputs at reset values, state IDLE, enter ignored until start.
